// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the PC / branch-resolution stage: condition codes,
// PC FSM states and compare-flag bit positions.
package pc_branch_unit_pkg;

  typedef enum logic [2:0] {
    kBR_ALWAYS = 3'd0,
    kBR_EQ     = 3'd1,
    kBR_NE     = 3'd2,
    kBR_LT     = 3'd3,
    kBR_GT     = 3'd4,
    kBR_LE     = 3'd5,
    kBR_GE     = 3'd6,
    kBR_NEVER  = 3'd7
  } br_cond_t;

  typedef enum logic [1:0] {
    kPC_RUN,
    kPC_FLUSH,
    kPC_HALTED
  } pc_state_t;

  localparam int unsigned kFLAG_LT = 2;
  localparam int unsigned kFLAG_GT = 1;
  localparam int unsigned kFLAG_EQ = 0;

endpackage

// File: rtl/pc_branch_unit_cond_eval.sv
// Combinational branch-condition evaluator; shared with the decoder's static
// predictor, so it must stay purely combinational.
module branch_cond_eval
  import pc_branch_unit_pkg::*;
(
  input  logic [2:0] flags_i,
  input  br_cond_t   cond_i,
  output logic       taken_o
);

  logic lt, gt, eq;

  assign lt = flags_i[kFLAG_LT];
  assign gt = flags_i[kFLAG_GT];
  assign eq = flags_i[kFLAG_EQ];

  always_comb begin
    taken_o = 1'b0;
    unique case (cond_i)
      kBR_ALWAYS: taken_o = 1'b1;
      kBR_EQ:     taken_o = eq;
      kBR_NE:     taken_o = !eq;
      kBR_LT:     taken_o = lt;
      kBR_GT:     taken_o = gt;
      kBR_LE:     taken_o = lt | eq;
      kBR_GE:     taken_o = gt | eq;
      kBR_NEVER:  taken_o = 1'b0;
      default:    taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter, compare-flag register and branch resolution with RUN/FLUSH/HALTED FSM.
// Optional macro PANDA_FLAG_BYPASS_EN lets a same-cycle CMP feed the branch condition.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int unsigned             PC_WIDTH     = 10,
  parameter int unsigned             OFFSET_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]     RESET_PC     = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    flag_we,
  input  logic                    LT,
  input  logic                    GT,
  input  logic                    EQ,
  input  logic                    branch_valid,
  input  logic [2:0]              branch_cond,
  input  logic                    jump_abs,
  input  logic [OFFSET_WIDTH-1:0] branch_offset,
  input  logic [PC_WIDTH-1:0]     jump_target,
  input  logic                    halt,
  output logic [PC_WIDTH-1:0]     pc,
  output logic [2:0]              flags,
  output logic                    flush,
  output logic                    halted
);

  pc_state_t             state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [2:0]            flags_q, flags_d;
  logic                  flush_q, flush_d;
  logic                  halted_q, halted_d;

  logic [2:0]            alu_flags;
  logic [2:0]            eval_flags;
  logic                  cond_true;
  logic                  taken;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic [PC_WIDTH-1:0]   rel_target;
  logic [PC_WIDTH-1:0]   target;

  assign alu_flags = {LT, GT, EQ};

`ifdef PANDA_FLAG_BYPASS_EN
  // Fused CMP+branch: the branch sees the flags being written this cycle.
  assign eval_flags = (flag_we && branch_valid) ? alu_flags : flags_q;
`else
  assign eval_flags = flags_q;
`endif

  branch_cond_eval u_cond_eval (
    .flags_i (eval_flags),
    .cond_i  (br_cond_t'(branch_cond)),
    .taken_o (cond_true)
  );

  assign taken      = branch_valid && cond_true;
  assign pc_inc     = pc_q + PC_WIDTH'(1);
  assign rel_target = pc_q + PC_WIDTH'($signed(branch_offset));
  assign target     = jump_abs ? jump_target : rel_target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= kPC_RUN;
    end else if (!stall) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      kPC_RUN: begin
        if (halt)       state_d = kPC_HALTED;
        else if (taken) state_d = kPC_FLUSH;
      end
      kPC_FLUSH:  state_d = kPC_RUN;
      kPC_HALTED: state_d = kPC_HALTED;
      default:    state_d = kPC_RUN;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    flags_d  = flags_q;
    flush_d  = 1'b0;
    halted_d = 1'b0;
    unique case (state_q)
      kPC_RUN: begin
        if (flag_we) flags_d = alu_flags;
        if (halt) begin
          halted_d = 1'b1;
        end else if (taken) begin
          pc_d    = target;
          flush_d = 1'b1;
        end else begin
          pc_d = pc_inc;
        end
      end
      kPC_FLUSH: pc_d = pc_inc;
      kPC_HALTED: halted_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      flags_q  <= '0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
    end else if (!stall) begin
      pc_q     <= pc_d;
      flags_q  <= flags_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
    end
  end

  assign pc     = pc_q;
  assign flags  = flags_q;
  assign flush  = flush_q;
  assign halted = halted_q;

endmodule
